// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with a shared prescaler and period counter and double-buffered compares.
// Optional: define PWM_BANK_POLARITY_EN to add a per-channel output polarity register at address 11.
module pwm_bank #(
  parameter int NUM_CH    = 8,
  parameter int CNT_WIDTH = 8,
  parameter int DIV_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [3:0]           wr_addr,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_tick,
  output logic                 wr_err
);
  localparam logic [3:0]           ADDR_DIV  = 4'd8;
  localparam logic [3:0]           ADDR_TOP  = 4'd9;
  localparam logic [3:0]           ADDR_CTRL = 4'd10;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_pre_cnt;
  logic [CNT_WIDTH-1:0] r_top_sh;
  logic [CNT_WIDTH-1:0] r_top_act;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_cmp_sh  [NUM_CH];
  logic [CNT_WIDTH-1:0] r_cmp_act [NUM_CH];
  logic                 r_en;
  logic                 r_mode;
  logic                 r_dir_down;

  logic [NUM_CH-1:0]    w_wr_cmp;
  logic                 w_wr_div;
  logic                 w_wr_top;
  logic                 w_wr_ctrl;
  logic                 w_wr_pol;
  logic                 w_unmapped;
  logic [CNT_WIDTH-1:0] w_top_next;
  logic [CNT_WIDTH-1:0] w_cmp_next [NUM_CH];
  logic                 w_hold;
  logic                 w_tick;
  logic                 w_wrap;
  logic                 w_load;
  logic                 w_dir_step;
  logic [CNT_WIDTH-1:0] w_cnt_step;
  logic [NUM_CH-1:0]    w_raw;
  logic [NUM_CH-1:0]    w_pol;

`ifdef PWM_BANK_POLARITY_EN
  logic [NUM_CH-1:0] r_pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_pol <= '0;
    else if (w_wr_pol) r_pol <= wr_data[NUM_CH-1:0];
  end

  assign w_pol = r_pol;
`else
  assign w_pol = '0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_wr_cmp  = '0;
    w_wr_div  = wr_valid && (wr_addr == ADDR_DIV);
    w_wr_top  = wr_valid && (wr_addr == ADDR_TOP);
    w_wr_ctrl = wr_valid && (wr_addr == ADDR_CTRL);
`ifdef PWM_BANK_POLARITY_EN
    w_wr_pol  = wr_valid && (wr_addr == 4'd11);
`else
    w_wr_pol  = 1'b0;
`endif
    for (int n = 0; n < NUM_CH; n++) begin
      w_wr_cmp[n]   = wr_valid && (int'(wr_addr) == n);
      w_cmp_next[n] = w_wr_cmp[n] ? wr_data : r_cmp_sh[n];
      w_raw[n]      = r_cnt < r_cmp_act[n];
    end
    w_unmapped = wr_valid && !(|w_wr_cmp) && !w_wr_div && !w_wr_top && !w_wr_ctrl && !w_wr_pol;
    w_top_next = w_wr_top ? wr_data : r_top_sh;

    // Disabled, disabling, or switching mode: counter parks at 0/up and actives reload.
    w_hold = !r_en || (w_wr_ctrl && (!wr_data[0] || (wr_data[1] != r_mode)));
    w_tick = r_en && (r_pre_cnt == r_div);

    w_cnt_step = r_cnt;
    w_dir_step = r_dir_down;
    w_wrap     = 1'b0;
    if (!r_mode || (r_top_act == '0)) begin
      if (r_cnt >= r_top_act) begin
        w_cnt_step = '0;
        w_dir_step = 1'b0;
        w_wrap     = 1'b1;
      end else begin
        w_cnt_step = r_cnt + CNT_ONE;
      end
    end else if (!r_dir_down) begin
      if (r_cnt >= r_top_act) begin
        w_cnt_step = r_cnt - CNT_ONE;
        w_dir_step = 1'b1;
      end else begin
        w_cnt_step = r_cnt + CNT_ONE;
        w_dir_step = ((r_cnt + CNT_ONE) == r_top_act);
      end
    end else if (r_cnt <= CNT_ONE) begin
      w_cnt_step = '0;
      w_dir_step = 1'b0;
      w_wrap     = 1'b1;
    end else begin
      w_cnt_step = r_cnt - CNT_ONE;
    end

    w_load = w_hold || (w_tick && w_wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_div       <= '0;
      r_pre_cnt   <= '0;
      r_top_sh    <= '1;
      r_top_act   <= '1;
      r_cnt       <= '0;
      r_en        <= 1'b0;
      r_mode      <= 1'b0;
      r_dir_down  <= 1'b0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      wr_err      <= 1'b0;
      // NOTE: compare arrays are reset explicitly because their zero state is visible at the outputs.
      for (int n = 0; n < NUM_CH; n++) begin
        r_cmp_sh[n]  <= '0;
        r_cmp_act[n] <= '0;
      end
    end else begin
      wr_err      <= w_unmapped;
      period_tick <= 1'b0;
      if (w_wr_div) r_div    <= wr_data[DIV_WIDTH-1:0];
      if (w_wr_top) r_top_sh <= wr_data;
      if (w_wr_ctrl) begin
        r_en   <= wr_data[0];
        r_mode <= wr_data[1];
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_wr_cmp[n]) r_cmp_sh[n] <= wr_data;
        if (w_load)      r_cmp_act[n] <= w_cmp_next[n];
      end
      if (w_load) r_top_act <= w_top_next;

      if (w_hold) begin
        r_cnt      <= '0;
        r_dir_down <= 1'b0;
        r_pre_cnt  <= '0;
      end else begin
        r_pre_cnt <= (w_wr_div || w_tick) ? '0 : r_pre_cnt + DIV_ONE;
        if (w_tick) begin
          r_cnt       <= w_cnt_step;
          r_dir_down  <= w_dir_step;
          period_tick <= w_wrap;
        end
      end

      pwm_out <= r_en ? (w_raw ^ w_pol) : w_pol;
    end
  end

endmodule
